// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: buffers a coefficient set and a sample block written
// by the host, then on start plays them out to an n_tap_fir. The sequence is
// a coefficient-load request, LENGTH back-to-back coefficients, the sample
// stream (stallable by hold), and a stop pulse.
// Every output is a register. The combinational block computes the value each
// output takes in the next cycle. hold is sampled at the clock edge that opens
// each DATA cycle.
module fir_stream_sequencer #(
  parameter  int LENGTH      = 10,
  parameter  int DATA_WIDTH  = 8,
  parameter  int MAX_SAMPLES = 64,
  localparam int SW          = $clog2(MAX_SAMPLES + 1),
  localparam int KW          = $clog2(LENGTH),
  localparam int AW          = $clog2(MAX_SAMPLES)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         coeff_wr_en,
  input  logic [KW-1:0]                coeff_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] coeff_wr_data,
  input  logic                         data_wr_en,
  input  logic [AW-1:0]                data_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] data_wr_data,
  input  logic                         start,
  input  logic [SW-1:0]                sample_count,
  input  logic                         hold,
  output logic                         load_coefficients_flag,
  output logic signed [DATA_WIDTH-1:0] coefficient_out,
  output logic                         load_data_flag,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         stop_data_load_flag,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_COEFF,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  // Buffers are never reset: contents survive a reset so a replay reuses them.
  logic signed [DATA_WIDTH-1:0] r_coeff   [LENGTH];
  logic signed [DATA_WIDTH-1:0] r_samples [MAX_SAMPLES];

  state_t                       r_state;
  logic [KW-1:0]                r_k;      // coefficient index being driven
  logic [SW-1:0]                r_i;      // samples issued so far
  logic [SW-1:0]                r_count;  // samples to issue this playout

  state_t                       w_state_n;
  logic [KW-1:0]                w_k_n;
  logic [KW-1:0]                w_k_inc;
  logic [SW-1:0]                w_i_n;
  logic [SW-1:0]                w_count_n;
  logic [SW-1:0]                w_count_clamped;
  logic                         w_lcf_n;
  logic signed [DATA_WIDTH-1:0] w_coef_n;
  logic                         w_ldf_n;
  logic signed [DATA_WIDTH-1:0] w_data_n;
  logic                         w_stop_n;
  logic                         w_busy_n;
  logic                         w_done_n;
  logic                         w_coeff_wr_ok;
  logic                         w_data_wr_ok;

  assign w_k_inc         = r_k + KW'(1);
  assign w_count_clamped = (sample_count > SW'(MAX_SAMPLES)) ? SW'(MAX_SAMPLES)
                                                             : sample_count;
  assign w_coeff_wr_ok   = (r_state == S_IDLE) && coeff_wr_en &&
                           (int'(coeff_wr_addr) < LENGTH);
  assign w_data_wr_ok    = (r_state == S_IDLE) && data_wr_en &&
                           (int'(data_wr_addr) < MAX_SAMPLES);

  // Buffer writes: accepted only while idle and in range, otherwise dropped.
  always_ff @(posedge clock) begin
    if (w_coeff_wr_ok) r_coeff[coeff_wr_addr]  <= coeff_wr_data;
    if (w_data_wr_ok)  r_samples[data_wr_addr] <= data_wr_data;
  end

  // Next state and next registered output values.
  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_i_n     = r_i;
    w_count_n = r_count;
    w_lcf_n   = 1'b0;
    w_coef_n  = coefficient_out;
    w_ldf_n   = 1'b0;
    w_data_n  = data_out;
    w_stop_n  = 1'b0;
    w_done_n  = 1'b0;
    w_busy_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_REQ;
          w_count_n = w_count_clamped;
          w_i_n     = '0;
          w_k_n     = '0;
          w_lcf_n   = 1'b1;
        end
      end
      S_REQ: begin
        w_state_n = S_COEFF;
        w_k_n     = '0;
        w_coef_n  = r_coeff[0];
      end
      S_COEFF: begin
        if (r_k == KW'(LENGTH - 1)) begin
          if (r_count == '0) begin
            w_state_n = S_STOP;
            w_stop_n  = 1'b1;
          end else begin
            w_state_n = S_DATA;
            if (!hold) begin
              w_ldf_n  = 1'b1;
              w_data_n = r_samples[r_i[AW-1:0]];
              w_i_n    = r_i + SW'(1);
            end
          end
        end else begin
          w_k_n    = w_k_inc;
          w_coef_n = r_coeff[w_k_inc];
        end
      end
      S_DATA: begin
        if (r_i == r_count) begin
          w_state_n = S_STOP;
          w_stop_n  = 1'b1;
        end else if (!hold) begin
          w_ldf_n  = 1'b1;
          w_data_n = r_samples[r_i[AW-1:0]];
          w_i_n    = r_i + SW'(1);
        end
      end
      S_STOP: begin
        w_state_n = S_DONE;
        w_done_n  = 1'b1;
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
    w_busy_n = (w_state_n == S_REQ) || (w_state_n == S_COEFF) ||
               (w_state_n == S_DATA) || (w_state_n == S_STOP);
  end

  // State, counters and output registers; reset aborts any playout.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state                <= S_IDLE;
      r_k                    <= '0;
      r_i                    <= '0;
      r_count                <= '0;
      load_coefficients_flag <= 1'b0;
      coefficient_out        <= '0;
      load_data_flag         <= 1'b0;
      data_out               <= '0;
      stop_data_load_flag    <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
    end else begin
      r_state                <= w_state_n;
      r_k                    <= w_k_n;
      r_i                    <= w_i_n;
      r_count                <= w_count_n;
      load_coefficients_flag <= w_lcf_n;
      coefficient_out        <= w_coef_n;
      load_data_flag         <= w_ldf_n;
      data_out               <= w_data_n;
      stop_data_load_flag    <= w_stop_n;
      busy                   <= w_busy_n;
      done                   <= w_done_n;
    end
  end

endmodule
